game_input_conditioner: RTL and testbench

Conditions the raw board inputs (one push-button, `N_SW` slide switches) before they reach the game top level and its master FSM. Each input passes through a two-flop synchronizer and a per-input debounce counter; the block then produces clean levels plus single-cycle edge pulses. `key_press` is the fire/start strobe consumed by the master FSM; `sw` drives torpedo direction selection.

---
 rtl/game_input_conditioner.sv | 104 ++++++++++
 tb/tb_game_input_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/game_input_conditioner.sv
// game_input_conditioner: sync + debounce key/switches into clean levels and edge pulses; GAME_INPUT_AUTOREPEAT_EN adds key auto-repeat
module game_input_conditioner #(
  parameter int N_SW = 2,
  parameter int CNT_WIDTH = 16,
  parameter logic [CNT_WIDTH-1:0] DEBOUNCE_LIMIT = 16'd50000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int REPEAT_WIDTH = 24,
  parameter logic [REPEAT_WIDTH-1:0] REPEAT_DELAY = 24'd12000000,
  parameter logic [REPEAT_WIDTH-1:0] REPEAT_PERIOD = 24'd3000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_raw,
  input  logic [N_SW-1:0] sw_raw,
  output logic            key,
  output logic            key_press,
  output logic            key_release,
  output logic [N_SW-1:0] sw,
  output logic            sw_changed
);
  localparam int N = N_SW + 1;
  localparam logic [CNT_WIDTH-1:0] LIM_M1 = DEBOUNCE_LIMIT - 1'b1;
  logic [N-1:0] raw, s1_q, s2_q, st_q, st_d;
  logic [CNT_WIDTH-1:0] c_q [N];
  logic [CNT_WIDTH-1:0] c_d [N];
  logic press_d, release_d, sw_chg_d;
  logic key_press_q, key_release_q, sw_changed_q;
  assign raw = {sw_raw, key_raw ^ KEY_ACTIVE_LOW};
  // two-flop synchronizer; bit 0 is the key normalised to active-high
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end
  // per-input debounce: accept after LIMIT consecutive differing cycles, any match clears the count
  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i] = (s2_q[i] != st_q[i] && c_q[i] == LIM_M1) ? s2_q[i] : st_q[i];
      c_d[i] = (s2_q[i] == st_q[i] || c_q[i] == LIM_M1) ? '0 : c_q[i] + 1'b1;
    end
  end
  assign press_d = st_d[0] & ~st_q[0];
  assign release_d = ~st_d[0] & st_q[0];
  assign sw_chg_d = |(st_d[N-1:1] ^ st_q[N-1:1]);
  // accepted levels, counters and the release/switch pulses, all updated on the accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= '0;
      c_q <= '{default: '0};
      key_release_q <= 1'b0;
      sw_changed_q <= 1'b0;
    end else begin
      st_q <= st_d;
      c_q <= c_d;
      key_release_q <= release_d;
      sw_changed_q <= sw_chg_d;
    end
  end
`ifdef GAME_INPUT_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_t;
  localparam logic [REPEAT_WIDTH-1:0] RD_M1 = REPEAT_DELAY - 1'b1;
  localparam logic [REPEAT_WIDTH-1:0] RP_M1 = REPEAT_PERIOD - 1'b1;
  rep_t state_q;
  logic [REPEAT_WIDTH-1:0] r_q;
  logic rep_hit;
  assign rep_hit = (state_q == DELAY && r_q == RD_M1) || (state_q == REPEAT && r_q == RP_M1);
  // auto-repeat FSM: a release always wins and suppresses a coincident repeat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q <= '0;
      key_press_q <= 1'b0;
    end else begin
      key_press_q <= press_d | (rep_hit & ~release_d);
      if (release_d) begin
        state_q <= IDLE;
      end else if (press_d) begin
        state_q <= DELAY;
        r_q <= '0;
      end else if (state_q != IDLE) begin
        r_q <= rep_hit ? '0 : r_q + 1'b1;
        state_q <= rep_hit ? REPEAT : state_q;
      end
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  // single press pulse per accepted press
  always_ff @(posedge clk) begin
    if (reset) key_press_q <= 1'b0;
    else key_press_q <= press_d;
  end
`endif
  assign key = st_q[0];
  assign sw = st_q[N-1:1];
  assign key_press = key_press_q;
  assign key_release = key_release_q;
  assign sw_changed = sw_changed_q;
endmodule

// File: tb/tb_game_input_conditioner.sv
// tb_game_input_conditioner: scoreboard bench for game_input_conditioner with DEBOUNCE_LIMIT=4
module tb_game_input_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_raw = 1'b1;
  logic [1:0] sw_raw = 2'b00;
  logic key, key_press, key_release, sw_changed;
  logic [1:0] sw;
  game_input_conditioner #(
    .N_SW(2), .CNT_WIDTH(16), .DEBOUNCE_LIMIT(16'd4), .KEY_ACTIVE_LOW(1'b1),
    .REPEAT_WIDTH(24), .REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd5)
  ) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .sw_raw(sw_raw), .key(key),
    .key_press(key_press), .key_release(key_release), .sw(sw), .sw_changed(sw_changed)
  );
  always #5 clk = ~clk;
  // pulse vector p = {sw_changed, key_release, key_press}; c = negedge count at which it is visible
  typedef struct {int c; logic [2:0] p;} ev_t;
  ev_t q[$];
  ev_t e;
  logic [2:0] obs;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc++;
  // a raw change driven at negedge n is sampled at edge n+1 and accepted at edge n+6
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {sw_changed, key_release, key_press};
      while (q.size() != 0 && q[0].c < cyc) begin
        checks++;
        failures++;
        $display("FAIL pulse_missing cyc=%0d actual=none required=%b", q[0].c, q[0].p);
        void'(q.pop_front());
      end
      if (q.size() != 0 && q[0].c == cyc) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.p) begin
          failures++;
          $display("FAIL pulse cyc=%0d actual=%b required=%b", cyc, obs, e.p);
        end
      end else if (obs !== 3'b000) begin
        checks++;
        failures++;
        $display("FAIL pulse_unexpected cyc=%0d actual=%b required=000", cyc, obs);
      end
    end
  end
  task automatic test_reset();
    reset = 1'b1;
    key_raw = 1'b1;
    sw_raw = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({key, key_press, key_release, sw, sw_changed} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b required=000000", {key, key_press, key_release, sw, sw_changed});
    end
    mon_en = 1'b1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({key, sw} !== 3'b000) begin
      failures++;
      $display("FAIL idle_levels actual=%b required=000", {key, sw});
    end
  endtask
  task automatic test_press();
    int a, rel;
    key_raw = 1'b0;
    a = cyc + 6;
    rel = a + 56;
    q.push_back(ev_t'{c: a, p: 3'b001});
`ifdef GAME_INPUT_AUTOREPEAT_EN
    for (int t = a + 10; t < rel; t += 5) q.push_back(ev_t'{c: t, p: 3'b001});
`endif
    q.push_back(ev_t'{c: rel, p: 3'b010});
    repeat (5) @(negedge clk);
    checks++;
    if (key !== 1'b0) begin
      failures++;
      $display("FAIL press_early actual=%b required=0", key);
    end
    @(negedge clk);
    checks++;
    if (key !== 1'b1) begin
      failures++;
      $display("FAIL press_level actual=%b required=1", key);
    end
    repeat (50) @(negedge clk);
    key_raw = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (key !== 1'b0) begin
      failures++;
      $display("FAIL release_level actual=%b required=0", key);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_bounce();
    key_raw = 1'b0;
    repeat (3) @(negedge clk);
    key_raw = 1'b1;
    @(negedge clk);
    key_raw = 1'b0;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b001});
    repeat (5) @(negedge clk);
    checks++;
    if (key !== 1'b0) begin
      failures++;
      $display("FAIL bounce_level actual=%b required=0", key);
    end
    @(negedge clk);
    checks++;
    if (key !== 1'b1) begin
      failures++;
      $display("FAIL bounce_accept actual=%b required=1", key);
    end
    key_raw = 1'b1;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b010});
    repeat (8) @(negedge clk);
  endtask
  task automatic test_switch();
    sw_raw = 2'b11;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b100});
    repeat (6) @(negedge clk);
    checks++;
    if (sw !== 2'b11) begin
      failures++;
      $display("FAIL sw_11 actual=%b required=11", sw);
    end
    sw_raw = 2'b10;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b100});
    repeat (6) @(negedge clk);
    checks++;
    if (sw !== 2'b10) begin
      failures++;
      $display("FAIL sw_10 actual=%b required=10", sw);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    key_raw = 1'b0;
    sw_raw = 2'b01;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b101});
    repeat (6) @(negedge clk);
    checks++;
    if ({key, sw} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_press actual=%b required=101", {key, sw});
    end
    key_raw = 1'b1;
    sw_raw = 2'b00;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b110});
    repeat (6) @(negedge clk);
    checks++;
    if ({key, sw} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_release actual=%b required=000", {key, sw});
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    key_raw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({key, key_press, key_release, sw, sw_changed} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_outputs actual=%b required=000000", {key, key_press, key_release, sw, sw_changed});
    end
    reset = 1'b0;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b001});
    repeat (5) @(negedge clk);
    checks++;
    if (key !== 1'b0) begin
      failures++;
      $display("FAIL midreset_restart actual=%b required=0", key);
    end
    @(negedge clk);
    checks++;
    if (key !== 1'b1) begin
      failures++;
      $display("FAIL midreset_accept actual=%b required=1", key);
    end
    key_raw = 1'b1;
    q.push_back(ev_t'{c: cyc + 6, p: 3'b010});
    repeat (8) @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_switch();
    test_back_to_back();
    test_reset_mid();
    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
